// File: rtl/h264_sched_pkg.sv
// h264_sched_pkg: shared constants, FSM state type and the 4x4 scan-order
// mapping used by the intra-4x4 macroblock scheduler.
package h264_sched_pkg;

    localparam int LUMA_BLKS   = 16;  // luma 4x4 blocks per MB
    localparam int CHROMA_BLKS = 8;   // 4 Cb then 4 Cr
    localparam int IDX_W       = 5;   // holds LUMA_BLKS+CHROMA_BLKS-1

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_WAIT_FB   = 3'd3,
        S_NEXT      = 3'd4,
        S_FINISH    = 3'd5
    } sched_state_e;

    // Block number -> {x[1:0], y[1:0]}. Luma blocks follow the H.264 double-Z
    // scan (x from bits 2,0; y from bits 3,1); each chroma plane is a 2x2 Z.
    function automatic logic [3:0] blk_xy(input logic [IDX_W-1:0] n);
        logic [1:0] x;
        logic [1:0] y;
        if (n >= IDX_W'(LUMA_BLKS)) begin
            x = {1'b0, n[0]};
            y = {1'b0, n[1]};
        end else begin
            x = {n[2], n[0]};
            y = {n[3], n[1]};
        end
        return {x, y};
    endfunction

endpackage

// File: rtl/h264_intra_mb_scheduler.sv
// h264_intra_mb_scheduler: walks one macroblock through the intra-4x4 block
// engine (16 luma then 8 chroma blocks), one block in flight at a time,
// waiting for completion, luma reconstruction feedback and output ready.
// Optional build macro H264_SCHED_STATS_EN adds the stall_cnt output.
module h264_intra_mb_scheduler
    import h264_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             mb_start,
    input  logic             abort,
    output logic             blk_start,
    output logic [IDX_W-1:0] blk_idx,
    output logic [1:0]       blk_x,
    output logic [1:0]       blk_y,
    output logic             blk_chroma,
    input  logic             blk_done,
    input  logic             fb_strobe,
    input  logic             out_ready,
    output logic             mb_busy,
    output logic             mb_done
`ifdef H264_SCHED_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUMA_BLKS + CHROMA_BLKS - 1);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [1:0]       blk_x_q, blk_x_d;
    logic [1:0]       blk_y_q, blk_y_d;
    logic             blk_chroma_q, blk_chroma_d;
    logic             mb_busy_q, mb_busy_d;

    // Next-state logic plus the single-cycle blk_start / mb_done strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        blk_start = 1'b0;
        mb_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mb_start) begin
                    state_d   = S_ISSUE;
                    blk_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                if (out_ready) begin
                    blk_start = 1'b1;
                    state_d   = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Chroma needs no feedback; feedback arriving with done counts.
                if (blk_done) begin
                    state_d = (blk_chroma_q || fb_strobe) ? S_NEXT : S_WAIT_FB;
                end
            end
            S_WAIT_FB: begin
                if (fb_strobe) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (blk_cnt_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_FINISH: begin
                mb_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a pending start or finish.
        if (abort) begin
            state_d   = S_IDLE;
            blk_cnt_d = '0;
            blk_start = 1'b0;
            mb_done   = 1'b0;
        end
    end

    // Block coordinates follow the counter so they are stable ISSUE..NEXT.
    always_comb begin
        {blk_x_d, blk_y_d} = blk_xy(blk_cnt_d);
        blk_chroma_d       = (blk_cnt_d >= IDX_W'(LUMA_BLKS));
        mb_busy_d          = (state_d != S_IDLE);
    end

    // State and registered block descriptor.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of its neighbours.
        if (reset) begin
            state_q      <= S_IDLE;
            blk_cnt_q    <= '0;
            blk_x_q      <= '0;
            blk_y_q      <= '0;
            blk_chroma_q <= 1'b0;
            mb_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_x_q      <= blk_x_d;
            blk_y_q      <= blk_y_d;
            blk_chroma_q <= blk_chroma_d;
            mb_busy_q    <= mb_busy_d;
        end
    end

    assign blk_idx    = blk_cnt_q;
    assign blk_x      = blk_x_q;
    assign blk_y      = blk_y_q;
    assign blk_chroma = blk_chroma_q;
    assign mb_busy    = mb_busy_q;

`ifdef H264_SCHED_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_cyc;
    logic        start_ok;

    // Stall counter: cycles blocked by downstream or waiting for feedback.
    always_comb begin
        start_ok    = (state_q == S_IDLE) && mb_start && !abort;
        stall_cyc   = ((state_q == S_ISSUE) && !out_ready) || (state_q == S_WAIT_FB);
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
        end else if (stall_cyc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
